issue_scheduler: RTL and testbench

In-order dual-issue scheduler that sits between the instruction queue and the reservation stations. Each cycle it decodes the two head instructions, checks register hazards against a scoreboard and reservation-station credits, and drives the queue's 0/1/2 `shift_count`. Issued instructions go out as registered per-slot packets tagged with their functional unit. Writeback and reservation-station release ports retire scoreboard entries and return credits.

---
 rtl/issue_pkg.sv | 31 +++
 rtl/issue_decode.sv | 38 +++
 rtl/issue_scheduler.sv | 123 ++++++++++++
 tb/tb_issue_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared decode types and opcode constants for the dual-issue scheduler.
package issue_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    FU_LSU = 2'd0,
    FU_ALU = 2'd1,
    FU_MDU = 2'd2
  } fu_t;

  typedef struct packed {
    fu_t        fu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rd;
  } dec_t;

  // True when no used source and the destination are free in the scoreboard.
  function automatic logic regs_ready(dec_t d, logic [31:0] busy);
    return !(d.use_rs1 && busy[d.rs1]) &&
           !(d.use_rs2 && busy[d.rs2]) &&
           !busy[d.rd];
  endfunction

endpackage

// File: rtl/issue_decode.sv
// Per-slot combinational decode: functional unit, used sources and destination.
module issue_decode
  import issue_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic unused_funct3;
  assign unused_funct3 = ^instr[14:12];

  always_comb begin
    dec = '{fu: FU_ALU, rs1: '0, rs2: '0, use_rs1: 1'b0, use_rs2: 1'b0, rd: '0};
    case (instr[6:0])
      OPC_LOAD: begin
        dec.fu      = FU_LSU;
        dec.rs1     = instr[19:15];
        dec.use_rs1 = 1'b1;
        dec.rd      = instr[11:7];
      end
      OPC_OP: begin
        dec.fu      = (instr[31:25] == F7_MULDIV) ? FU_MDU : FU_ALU;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        dec.rd      = instr[11:7];
      end
      OPC_OPIMM: begin
        dec.rs1     = instr[19:15];
        dec.use_rs1 = 1'b1;
        dec.rd      = instr[11:7];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler with register scoreboard and per-FU RS credits.
// Dual issue is built only when ISSUE_DUAL_EN is defined; otherwise slot 1 is tied off.
module issue_scheduler
  import issue_pkg::*;
#(
  parameter  int unsigned RS_DEPTH = 2,
  localparam int unsigned CW       = $clog2(RS_DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr1,
  input  logic [31:0] instr2,
  output logic [1:0]  shift_count,
  output logic        iss0_valid,
  output logic        iss1_valid,
  output logic [31:0] iss0_instr,
  output logic [31:0] iss1_instr,
  output logic [1:0]  iss0_fu,
  output logic [1:0]  iss1_fu,
  input  logic        wb0_valid,
  input  logic        wb1_valid,
  input  logic [4:0]  wb0_rd,
  input  logic [4:0]  wb1_rd,
  input  logic [2:0]  rs_release
);

  localparam int unsigned SW = CW + 1;

  logic [31:0]         busy, busy_nxt;
  logic [2:0][CW-1:0]  credit, credit_nxt;
  logic [SW-1:0]       sum;
  logic [2:0]          ovf;
  logic [2:0]          take0, take1;
  logic                iss0, iss1;
  dec_t                d0;

  issue_decode u_dec0 (.instr(instr1), .dec(d0));

  assign iss0  = (credit[d0.fu] != '0) && regs_ready(d0, busy);
  assign take0 = iss0 ? (3'b001 << d0.fu) : '0;

`ifdef ISSUE_DUAL_EN
  dec_t d1;
  logic cred1_ok, raw1, waw1;

  issue_decode u_dec1 (.instr(instr2), .dec(d1));

  // Slot 1 sees the credit left over after slot 0 takes its entry.
  assign cred1_ok = (d1.fu == d0.fu) ? (credit[d1.fu] > CW'(1)) : (credit[d1.fu] != '0);
  assign raw1 = (d0.rd != '0) &&
                ((d1.use_rs1 && (d1.rs1 == d0.rd)) || (d1.use_rs2 && (d1.rs2 == d0.rd)));
  assign waw1 = (d0.rd != '0) && (d1.rd == d0.rd);
  assign iss1 = iss0 && cred1_ok && !raw1 && !waw1 && regs_ready(d1, busy);
  assign take1 = iss1 ? (3'b001 << d1.fu) : '0;
`else
  logic unused_instr2;
  assign unused_instr2 = ^instr2;
  assign iss1  = 1'b0;
  assign take1 = '0;
`endif

  assign shift_count = reset ? 2'd0 : {iss1, iss0 & ~iss1};

  // Clears are applied before sets so a same-cycle issue keeps the bit busy.
  always_comb begin
    busy_nxt = busy;
    if (wb0_valid) busy_nxt[wb0_rd] = 1'b0;
    if (wb1_valid) busy_nxt[wb1_rd] = 1'b0;
    if (iss0) busy_nxt[d0.rd] = 1'b1;
`ifdef ISSUE_DUAL_EN
    if (iss1) busy_nxt[d1.rd] = 1'b1;
`endif
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    credit_nxt = credit;
    ovf        = '0;
    sum        = '0;
    for (int unsigned f = 0; f < 3; f++) begin
      sum = SW'(credit[f]) + SW'(rs_release[f]) - SW'(take0[f]) - SW'(take1[f]);
      ovf[f] = (sum > SW'(RS_DEPTH));
      credit_nxt[f] = ovf[f] ? CW'(RS_DEPTH) : sum[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      credit     <= {3{CW'(RS_DEPTH)}};
      iss0_valid <= 1'b0;
      iss0_instr <= '0;
      iss0_fu    <= '0;
    end else begin
      busy       <= busy_nxt;
      credit     <= credit_nxt;
      iss0_valid <= iss0;
      iss0_instr <= iss0 ? instr1 : '0;
      iss0_fu    <= iss0 ? d0.fu : FU_LSU;
    end
  end

`ifdef ISSUE_DUAL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      iss1_valid <= 1'b0;
      iss1_instr <= '0;
      iss1_fu    <= '0;
    end else begin
      iss1_valid <= iss1;
      iss1_instr <= iss1 ? instr2 : '0;
      iss1_fu    <= iss1 ? d1.fu : FU_LSU;
    end
  end
`else
  assign iss1_valid = 1'b0;
  assign iss1_instr = '0;
  assign iss1_fu    = '0;
`endif

  a_credit_overflow: assert property (@(posedge clk) disable iff (reset) (ovf == '0));

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed table-driven bench for issue_scheduler; dual-issue rows run when ISSUE_DUAL_EN is defined.
`timescale 1ns/1ps
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr1, instr2;
  logic [1:0]  shift_count;
  logic        iss0_valid, iss1_valid;
  logic [31:0] iss0_instr, iss1_instr;
  logic [1:0]  iss0_fu, iss1_fu;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [2:0]  rs_release;

  always #5 clk = ~clk;

  issue_scheduler #(.RS_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .instr1(instr1), .instr2(instr2),
    .shift_count(shift_count),
    .iss0_valid(iss0_valid), .iss1_valid(iss1_valid),
    .iss0_instr(iss0_instr), .iss1_instr(iss1_instr),
    .iss0_fu(iss0_fu), .iss1_fu(iss1_fu),
    .wb0_valid(wb0_valid), .wb1_valid(wb1_valid),
    .wb0_rd(wb0_rd), .wb1_rd(wb1_rd),
    .rs_release(rs_release)
  );

  // w0/w1: -1 none, 0..31 valid writeback, 100+n invalid strobe with rd=n.
  // fu0/fu1: -1 means no issue expected. busy/l/a/m: state after the edge.
  typedef struct {
    logic        rst;
    logic [31:0] i1, i2;
    int          w0, w1;
    logic [2:0]  rel;
    logic [1:0]  sh;
    int          fu0, fu1;
    logic [31:0] busy;
    int          l, a, m;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tab[$];

  function automatic vec_t row(logic rst, logic [31:0] i1, logic [31:0] i2, int w0, int w1,
                               logic [2:0] rel, logic [1:0] sh, int fu0, int fu1,
                               logic [31:0] busy, int l, int a, int m);
    vec_t v;
    v.rst = rst; v.i1 = i1; v.i2 = i2; v.w0 = w0; v.w1 = w1; v.rel = rel; v.sh = sh;
    v.fu0 = fu0; v.fu1 = fu1; v.busy = busy; v.l = l; v.a = a; v.m = m;
    return v;
  endfunction

  function automatic logic [31:0] b(int n);
    return 32'd1 << n;
  endfunction

  function automatic logic [31:0] lw(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] addi(int rd, int rs1);
    return {12'd1, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] add(int rd, int rs1, int rs2);
    return {7'b0000000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] mul(int rd, int rs1, int rs2);
    return {7'b0000001, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset      = v.rst;
    instr1     = v.i1;
    instr2     = v.i2;
    wb0_valid  = (v.w0 >= 0) && (v.w0 < 32);
    wb1_valid  = (v.w1 >= 0) && (v.w1 < 32);
    wb0_rd     = (v.w0 >= 0) ? 5'(v.w0 % 100) : 5'd0;
    wb1_rd     = (v.w1 >= 0) ? 5'(v.w1 % 100) : 5'd0;
    rs_release = v.rel;
    #1;
    check({tag, ".shift"}, 32'(shift_count), 32'(v.sh));
    @(posedge clk);
    #1;
    check({tag, ".v0"}, 32'(iss0_valid), 32'(v.fu0 >= 0));
    check({tag, ".v1"}, 32'(iss1_valid), 32'(v.fu1 >= 0));
    if (v.fu0 >= 0) begin
      check({tag, ".fu0"}, 32'(iss0_fu), 32'(v.fu0));
      check({tag, ".instr0"}, iss0_instr, v.i1);
    end
    if (v.fu1 >= 0) begin
      check({tag, ".fu1"}, 32'(iss1_fu), 32'(v.fu1));
      check({tag, ".instr1"}, iss1_instr, v.i2);
    end
    if (v.rst) begin
      check({tag, ".rst_instr0"}, iss0_instr, 32'd0);
      check({tag, ".rst_instr1"}, iss1_instr, 32'd0);
      check({tag, ".rst_fu"}, 32'({iss0_fu, iss1_fu}), 32'd0);
    end
    check({tag, ".busy"}, dut.busy, v.busy);
    check({tag, ".cred_lsu"}, 32'(dut.credit[0]), 32'(v.l));
    check({tag, ".cred_alu"}, 32'(dut.credit[1]), 32'(v.a));
    check({tag, ".cred_mdu"}, 32'(dut.credit[2]), 32'(v.m));
  endtask

  initial begin
    logic [31:0] oth;
    reset = 1'b1; instr1 = '0; instr2 = '0;
    wb0_valid = 1'b0; wb1_valid = 1'b0; wb0_rd = '0; wb1_rd = '0; rs_release = '0;
    oth = {7'd0, 5'd6, 5'd2, 3'd0, 5'd11, 7'b0110111};

    // Slot 1 is always blocked here, so these rows hold for either build.
    tab.push_back(row(1, lw(1,0,0),  lw(1,0,0),  -1, -1, 3'b000, 0, -1, -1, 32'd0, 2, 2, 2));
    tab.push_back(row(0, lw(1,0,0),  lw(1,0,0),  -1, -1, 3'b000, 1,  0, -1, b(1), 1, 2, 2));
    tab.push_back(row(0, lw(2,0,0),  lw(2,0,0),  -1, -1, 3'b000, 1,  0, -1, b(1)|b(2), 0, 2, 2));
    tab.push_back(row(0, lw(3,0,0),  lw(3,0,0),  -1, -1, 3'b001, 0, -1, -1, b(1)|b(2), 1, 2, 2));
    tab.push_back(row(0, lw(3,0,0),  lw(3,0,0),  -1, -1, 3'b000, 1,  0, -1, b(1)|b(2)|b(3), 0, 2, 2));
    tab.push_back(row(0, addi(5,0),  addi(5,0),  -1, -1, 3'b001, 1,  1, -1, b(1)|b(2)|b(3)|b(5), 1, 1, 2));
    tab.push_back(row(0, lw(4,0,0),  lw(4,0,0),  -1, -1, 3'b001, 1,  0, -1, b(1)|b(2)|b(3)|b(4)|b(5), 1, 1, 2));
    tab.push_back(row(0, add(6,1,7), add(6,1,7),  1, -1, 3'b000, 0, -1, -1, b(2)|b(3)|b(4)|b(5), 1, 1, 2));
    tab.push_back(row(0, add(6,1,7), add(6,1,7), -1, -1, 3'b000, 1,  1, -1, b(2)|b(3)|b(4)|b(5)|b(6), 1, 0, 2));
    tab.push_back(row(0, addi(7,0),  addi(7,0),  -1, -1, 3'b010, 0, -1, -1, b(2)|b(3)|b(4)|b(5)|b(6), 1, 1, 2));
    tab.push_back(row(0, add(8,0,3), add(8,0,3),  3,  3, 3'b010, 0, -1, -1, b(2)|b(4)|b(5)|b(6), 1, 2, 2));
    tab.push_back(row(0, add(8,0,3), add(8,0,3), -1, -1, 3'b000, 1,  1, -1, b(2)|b(4)|b(5)|b(6)|b(8), 1, 1, 2));
    tab.push_back(row(0, addi(2,0),  addi(2,0),   4,  5, 3'b000, 0, -1, -1, b(2)|b(6)|b(8), 1, 1, 2));
    tab.push_back(row(0, addi(9,0),  addi(9,0),   9, -1, 3'b000, 1,  1, -1, b(2)|b(6)|b(8)|b(9), 1, 0, 2));
    tab.push_back(row(0, lw(10,0,6), lw(10,0,6), -1, -1, 3'b010, 1,  0, -1, b(2)|b(6)|b(8)|b(9)|b(10), 0, 1, 2));
    tab.push_back(row(0, oth,        add(20,2,2), -1, -1, 3'b000, 1,  1, -1, b(2)|b(6)|b(8)|b(9)|b(10), 0, 0, 2));
    tab.push_back(row(0, mul(12,0,0), mul(12,0,0), 2,  6, 3'b000, 1,  2, -1, b(8)|b(9)|b(10)|b(12), 0, 0, 1));
    tab.push_back(row(0, mul(13,8,0), mul(13,8,0), 8, -1, 3'b100, 0, -1, -1, b(9)|b(10)|b(12), 0, 0, 2));
    tab.push_back(row(0, mul(13,8,0), mul(13,8,0),-1, -1, 3'b000, 1,  2, -1, b(9)|b(10)|b(12)|b(13), 0, 0, 1));
    tab.push_back(row(0, mul(14,0,0), mul(14,0,0), 9, -1, 3'b000, 1,  2, -1, b(10)|b(12)|b(13)|b(14), 0, 0, 0));
    tab.push_back(row(0, mul(15,0,0), mul(15,0,0),-1, -1, 3'b111, 0, -1, -1, b(10)|b(12)|b(13)|b(14), 1, 1, 1));
    tab.push_back(row(0, lw(16,10,0), lw(16,10,0), 110, 112, 3'b000, 0, -1, -1, b(10)|b(12)|b(13)|b(14), 1, 1, 1));
    tab.push_back(row(0, addi(0,0),  addi(0,0),  -1, -1, 3'b000, 1,  1, -1, b(10)|b(12)|b(13)|b(14), 1, 0, 1));
    tab.push_back(row(1, lw(30,0,0), lw(30,0,0), 10, -1, 3'b111, 0, -1, -1, 32'd0, 2, 2, 2));
    tab.push_back(row(0, lw(1,0,0),  lw(1,0,0),  -1, -1, 3'b000, 1,  0, -1, b(1), 1, 2, 2));

    foreach (tab[k]) apply(tab[k], $sformatf("v%0d", k));

`ifdef ISSUE_DUAL_EN
    apply(row(1, 32'h00b02083, 32'h00f02103, -1, -1, 3'b000, 0, -1, -1, 32'd0, 2, 2, 2), "d_rst");
    apply(row(0, 32'h00b02083, 32'h00f02103, -1, -1, 3'b000, 2,  0,  0, b(1)|b(2), 0, 2, 2), "d_lwlw");
    apply(row(0, addi(4,0),    32'h02408533,  1, -1, 3'b000, 1,  1, -1, b(2)|b(4), 0, 1, 2), "d_raw0");
    apply(row(0, 32'h02408533, addi(21,0),    4, -1, 3'b000, 0, -1, -1, b(2), 0, 1, 2), "d_mulwait");
    apply(row(0, 32'h02408533, 32'h025105b3,  2, -1, 3'b000, 1,  2, -1, b(10), 0, 1, 1), "d_mulgo");
    apply(row(1, 32'h025105b3, 32'h00b50833, -1, -1, 3'b000, 0, -1, -1, 32'd0, 2, 2, 2), "d_midrst");
    apply(row(0, 32'h025105b3, 32'h00b50833, -1, -1, 3'b000, 1,  2, -1, b(11), 2, 2, 1), "d_raw1");
    apply(row(0, 32'h00b50833, addi(22,0),   11, -1, 3'b000, 0, -1, -1, 32'd0, 2, 2, 1), "d_addwait");
    apply(row(0, 32'h00b50833, addi(23,0),   -1, -1, 3'b000, 2,  1,  1, b(16)|b(23), 2, 0, 1), "d_alu2");
    apply(row(0, lw(25,0,0),   mul(26,0,0),  -1, -1, 3'b000, 2,  0,  2, b(16)|b(23)|b(25)|b(26), 1, 0, 0), "d_mix");
    apply(row(0, lw(27,0,0),   lw(28,0,0),   -1, -1, 3'b000, 1,  0, -1, b(16)|b(23)|b(25)|b(26)|b(27), 0, 0, 0), "d_cred1");
`else
    apply(row(1, addi(1,0), addi(2,0), -1, -1, 3'b000, 0, -1, -1, 32'd0, 2, 2, 2), "s_rst");
    apply(row(0, addi(1,0), addi(2,0), -1, -1, 3'b000, 1,  1, -1, b(1), 2, 1, 2), "s_a");
    apply(row(0, addi(2,0), addi(3,0), -1, -1, 3'b000, 1,  1, -1, b(1)|b(2), 2, 0, 2), "s_b");
    apply(row(0, addi(3,0), addi(4,0), -1, -1, 3'b010, 0, -1, -1, b(1)|b(2), 2, 1, 2), "s_c");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
